// File: rtl/eth_arp_responder_tx_pkg.sv
// rtl/eth_arp_responder_tx_pkg.sv - shared Ethernet/ARP types, frame constants and CRC32 byte step
package eth_arp_responder_tx_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD           = 8'hD5;
    localparam int          ETH_MIN_PAYLOAD   = 46;
    localparam int          ETH_IPG_BYTES     = 12;
    localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam int          ARP_BYTES         = 28;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [2:0] {
        ETH_PREAMBLE,
        ETH_MAC_DESTINATION,
        ETH_MAC_SOURCE,
        ETH_ETHER_TYPE,
        ETH_PAYLOAD,
        ETH_CRC,
        ETH_INTERPACKET_GAP
    } e_eth_frame_section;

    typedef enum logic [15:0] {
        ARP_OPER_REQUEST = 16'd1,
        ARP_OPER_REPLY   = 16'd2
    } e_arp_oper;

    typedef enum logic [15:0] {
        ETHER_TYPE_IPV4 = 16'h0800,
        ETHER_TYPE_ARP  = 16'h0806,
        ETHER_TYPE_IPV6 = 16'h86DD
    } e_ether_type;

    typedef struct packed {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } st_arp_packet;

    // Number of bytes each transmitted section occupies on the wire
    function automatic logic [5:0] section_len(input e_eth_frame_section s);
        case (s)
            ETH_PREAMBLE:        return 6'd8;
            ETH_MAC_DESTINATION: return 6'd6;
            ETH_MAC_SOURCE:      return 6'd6;
            ETH_ETHER_TYPE:      return 6'd2;
            ETH_PAYLOAD:         return 6'(ETH_MIN_PAYLOAD);
            ETH_CRC:             return 6'd4;
            default:             return 6'd1;
        endcase
    endfunction

    // Reflected CRC32 update with one data byte (LSB of the byte first)
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte idx (0 = most significant) of an nbytes-wide field held in the low bits
    function automatic logic [7:0] msb_byte(input logic [223:0] field, input int nbytes, input int idx);
        logic [223:0] s;
        s = field >> (8 * (nbytes - 1 - idx));
        return s[7:0];
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// rtl/eth_crc32_byte.sv - byte-wide reflected CRC32 accumulator with registered result
module eth_crc32_byte
    import eth_arp_responder_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic [31:0] crc_next
);

    assign crc_next = crc32_byte(crc, data);

    // Restart on init, otherwise fold in one byte per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC32_INIT;
        end else if (init) begin
            crc <= CRC32_INIT;
        end else if (enable) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/eth_arp_responder_tx.sv
// rtl/eth_arp_responder_tx.sv - ARP reply framer/serialiser; ETH_ARP_TX_GRATUITOUS_EN adds announce
module eth_arp_responder_tx
    import eth_arp_responder_tx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0102
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef ETH_ARP_TX_GRATUITOUS_EN
    input  logic         announce,
`endif
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [223:0] req_packet,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic [15:0]  reply_count,
    output logic [15:0]  drop_count
);

    localparam logic [3:0] GAP_LAST = 4'(ETH_IPG_BYTES);

    e_eth_frame_section section, nxt_section;
    logic [5:0]   byte_idx, nxt_idx;
    logic [3:0]   gap_cnt;
    logic [47:0]  dest_mac, target_mac;
    logic [31:0]  target_ip;
    logic         is_announce;
    logic         last_in_section;
    logic [7:0]   nxt_byte;
    logic [15:0]  reply_oper;
    logic [223:0] arp_field;
    logic [31:0]  crc_q, crc_next, crc_src, crc_shift;
    logic         crc_init, crc_en;
    logic         req_take, req_ok, tx_take, announce_start;
    st_arp_packet req;
    logic         unused_req_tha;

    assign req     = req_packet;
    assign req_take = req_valid && req_ready;
    assign tx_take  = tx_valid && tx_ready;
    assign req_ok   = (req.htype == 16'd1) && (req.ptype == ETHER_TYPE_IPV4) &&
                      (req.hlen == 8'd6) && (req.plen == 8'd4) &&
                      (req.oper == ARP_OPER_REQUEST) && (req.tpa == LOCAL_IP);
    assign unused_req_tha = ^req.tha;
    assign reply_oper = is_announce ? ARP_OPER_REQUEST : ARP_OPER_REPLY;

`ifdef ETH_ARP_TX_GRATUITOUS_EN
    logic announce_pending;
    assign announce_start = announce_pending && req_ready && !req_valid;

    // Hold an announce until the idle slot; pulses while pending collapse into one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            announce_pending <= 1'b0;
        end else begin
            announce_pending <= (announce_pending && !announce_start) || announce;
        end
    end
`else
    assign announce_start = 1'b0;
`endif

    assign crc_init = (req_take && req_ok) || announce_start;
    assign crc_en   = tx_take && (section inside {ETH_MAC_DESTINATION, ETH_MAC_SOURCE,
                                                  ETH_ETHER_TYPE, ETH_PAYLOAD});

    eth_crc32_byte u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (crc_init),
        .enable   (crc_en),
        .data     (tx_data),
        .crc      (crc_q),
        .crc_next (crc_next)
    );

    // Next position in the frame and the byte that will be presented there
    always_comb begin
        last_in_section = (byte_idx == section_len(section) - 6'd1);
        nxt_section     = section;
        nxt_idx         = byte_idx + 6'd1;
        if (last_in_section) begin
            nxt_idx = '0;
            case (section)
                ETH_PREAMBLE:        nxt_section = ETH_MAC_DESTINATION;
                ETH_MAC_DESTINATION: nxt_section = ETH_MAC_SOURCE;
                ETH_MAC_SOURCE:      nxt_section = ETH_ETHER_TYPE;
                ETH_ETHER_TYPE:      nxt_section = ETH_PAYLOAD;
                ETH_PAYLOAD:         nxt_section = ETH_CRC;
                default:             nxt_section = ETH_INTERPACKET_GAP;
            endcase
        end
        arp_field = {16'h0001, ETHER_TYPE_IPV4, 8'd6, 8'd4, reply_oper,
                     LOCAL_MAC, LOCAL_IP, target_mac, target_ip};
        // FCS byte 0 is sent while the last pad byte is still being folded in
        crc_src   = (nxt_idx == 6'd0) ? crc_next : crc_q;
        crc_shift = crc_src >> {nxt_idx[1:0], 3'b000};
        nxt_byte  = 8'h00;
        case (nxt_section)
            ETH_PREAMBLE:        nxt_byte = (nxt_idx == 6'd7) ? ETH_SFD : ETH_PREAMBLE_BYTE;
            ETH_MAC_DESTINATION: nxt_byte = msb_byte({176'd0, dest_mac}, 6, int'(nxt_idx));
            ETH_MAC_SOURCE:      nxt_byte = msb_byte({176'd0, LOCAL_MAC}, 6, int'(nxt_idx));
            ETH_ETHER_TYPE:      nxt_byte = msb_byte({208'd0, ETHER_TYPE_ARP}, 2, int'(nxt_idx));
            ETH_PAYLOAD: begin
                if (nxt_idx < 6'(ARP_BYTES)) begin
                    nxt_byte = msb_byte(arp_field, ARP_BYTES, int'(nxt_idx));
                end
            end
            ETH_CRC:             nxt_byte = ~crc_shift[7:0];
            default:             nxt_byte = 8'h00;
        endcase
    end

    // Frame sequencer: idle/gap, request capture and byte-by-byte serialisation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            section     <= ETH_INTERPACKET_GAP;
            byte_idx    <= '0;
            gap_cnt     <= GAP_LAST;
            req_ready   <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            reply_count <= '0;
            drop_count  <= '0;
            dest_mac    <= '0;
            target_mac  <= '0;
            target_ip   <= '0;
            is_announce <= 1'b0;
        end else if (section == ETH_INTERPACKET_GAP) begin
            if (req_take && req_ok) begin
                dest_mac    <= req.sha;
                target_mac  <= req.sha;
                target_ip   <= req.spa;
                is_announce <= 1'b0;
                section     <= ETH_PREAMBLE;
                byte_idx    <= '0;
                tx_data     <= ETH_PREAMBLE_BYTE;
                tx_valid    <= 1'b1;
                tx_last     <= 1'b0;
                req_ready   <= 1'b0;
            end else if (req_take) begin
                drop_count <= drop_count + 16'd1;
            end else if (announce_start) begin
                dest_mac    <= ETH_BROADCAST_MAC;
                target_mac  <= '0;
                target_ip   <= LOCAL_IP;
                is_announce <= 1'b1;
                section     <= ETH_PREAMBLE;
                byte_idx    <= '0;
                tx_data     <= ETH_PREAMBLE_BYTE;
                tx_valid    <= 1'b1;
                tx_last     <= 1'b0;
                req_ready   <= 1'b0;
            end else if (gap_cnt != GAP_LAST) begin
                gap_cnt   <= gap_cnt + 4'd1;
                req_ready <= (gap_cnt == GAP_LAST - 4'd1);
            end else begin
                req_ready <= 1'b1;
            end
        end else if (tx_take) begin
            if (section == ETH_CRC && last_in_section) begin
                section  <= ETH_INTERPACKET_GAP;
                byte_idx <= '0;
                gap_cnt  <= 4'd1;
                tx_data  <= 8'h00;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
                if (!is_announce) begin
                    reply_count <= reply_count + 16'd1;
                end
            end else begin
                section  <= nxt_section;
                byte_idx <= nxt_idx;
                tx_data  <= nxt_byte;
                tx_last  <= (nxt_section == ETH_CRC) && (nxt_idx == 6'd3);
            end
        end
    end

endmodule

// File: doc/eth_arp_responder_tx.md
Name: eth_arp_responder_tx

Overview:
- Transmit-side counterpart of the Ethernet/ARP receive path.
- Accepts one parsed ARP packet (st_arp_packet) per handshake and filters it.
- For a valid ARP request addressed to our IP, serialises a complete Ethernet ARP reply as a byte stream for the PHY/MAC adapter: preamble, SFD, header, payload, padding, CRC32, then interpacket gap.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, our MAC address; used as Ethernet source and ARP sender hardware address.
- LOCAL_IP, 32'hC0A8_0102, our IPv4 address (192.168.1.2); matched against the request target protocol address.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  parsed ARP packet available.
- req_ready  out  1  block can accept a packet.
- req_packet  in  224  st_arp_packet from the receive path.
- tx_data  out  8  frame byte, on-wire order.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the byte.
- tx_last  out  1  marks the final CRC byte.
- reply_count  out  16  replies fully sent; wraps.
- drop_count  out  16  packets accepted but not answered; wraps.

Behaviour:
Reset values:
- tx_data=0, tx_valid=0, tx_last=0, req_ready=0, counters=0.
- req_ready is registered and rises on the first clk edge after rst_n deasserts.

Input handshake and filtering:
- req_ready=1 only in ETH_INTERPACKET_GAP with the gap counter done (the idle condition).
- A packet is captured on req_valid&&req_ready; req_ready drops the next cycle.
- Answer only if: htype=1, ptype=16'h0800, hlen=6, plen=4, oper=ARP_OPER_REQUEST, target_protocol_address==LOCAL_IP.
- Any other packet: drop_count++, stay idle, req_ready remains 1.

FSM:
- Uses e_eth_frame_section; byte index counter is 6 bits.
- ETH_PREAMBLE: 7x 8'h55 then 8'hD5.
- ETH_MAC_DESTINATION: 6 bytes = request sender_hardware_address.
- ETH_MAC_SOURCE: 6 bytes = LOCAL_MAC.
- ETH_ETHER_TYPE: 8'h08, 8'h06.
- ETH_PAYLOAD: 46 bytes, made of:
  - 28 ARP bytes: htype 1, ptype 0800, hlen 6, plen 4, oper 2, sha=LOCAL_MAC, spa=LOCAL_IP, tha=req sha, tpa=req spa;
  - followed by 18 zero bytes.
- ETH_CRC: 4 bytes.
- Multi-byte fields go out MSB byte first. Frame length is 72 bytes.

Stream rules:
- A byte advances only on tx_valid&&tx_ready.
- While tx_ready=0, tx_data, tx_valid and tx_last hold stable.
- tx_valid stays continuously 1 from the first preamble byte to the last CRC byte.
- There is no source-side bubble; the first byte is presented the cycle after capture.

CRC:
- Covers destination MAC through the last pad byte; the preamble is excluded.
- Reflected CRC32: poly 32'hEDB88320, init 32'hFFFFFFFF, output = ~crc.
- FCS is sent low byte first; tx_last=1 with the 4th FCS byte only.

Interpacket gap:
- After the last FCS handshake: reply_count++, enter ETH_INTERPACKET_GAP with tx_valid=0.
- The gap counts 12 clk cycles independent of tx_ready, then req_ready=1.

Reset mid-frame: all outputs return to reset values immediately (asynchronous), the captured packet is discarded, and no counter increments.

Optional Feature:
Macro ETH_ARP_TX_GRATUITOUS_EN.
- Defined:
  - Adds input announce (1 bit, pulse), latched into a pending flag.
  - When idle and no request handshake is taken that cycle, sends a gratuitous ARP:
    - destination ff:ff:ff:ff:ff:ff, oper=1;
    - sha=LOCAL_MAC, spa=tpa=LOCAL_IP, tha=0.
  - A simultaneous req_valid wins; the announce stays pending.
  - Pulses arriving while an announce is pending merge into one.
  - A completed announce does not increment reply_count.
- Undefined: the port is absent; behaviour is exactly as above.

Decomposition:
- Shared package additions:
  - ETH_PREAMBLE_BYTE=8'h55, ETH_SFD=8'hD5;
  - ETH_MIN_PAYLOAD=46, ETH_IPG_BYTES=12;
  - ETH_BROADCAST_MAC;
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE=32'hDEBB20E3.
- Reused from the package: e_eth_frame_section, st_arp_packet, e_arp_oper, e_ether_type.
- Sub-module eth_crc32_byte: byte-wide, init/enable inputs, registered crc output. The receive side will reuse it for FCS check.

Test Plan:
1. Request from 10.0.0.5 / aa:bb:cc:dd:ee:01, tpa=192.168.1.2, tx_ready=1 -> exactly 72 bytes:
   - 55x7, D5, then dest aa..01, src 02..01, 08 06;
   - ARP 0001 0800 06 04 0002…, 18 zero bytes;
   - running CRC over dest..FCS = 32'hDEBB20E3;
   - tx_last only on byte 72; reply_count=1.
2. Request with tpa=192.168.1.3, then oper=2, then ptype=86DD -> no tx_valid; drop_count=3; req_ready stays 1.
3. Random tx_ready stalls (50%) during scenario 1 -> identical byte sequence; data, valid and last stable while stalled.
4. Back-to-back requests -> req_ready low through the frame, then exactly 12 cycles of tx_valid=0 after the last byte; second frame identical in form.
5. rst_n low at payload byte 10 -> tx_valid=0 the same cycle (asynchronous); after release, req_ready=1 one edge later; reply_count=0.
6. (GRATUITOUS_EN) announce pulse together with req_valid -> reply first, then broadcast frame with oper=1 and spa=tpa=C0A80102; reply_count=1.
